// File: rtl/frame_update_sequencer.sv
// Per-frame scheduler: latches the controller word, triggers each enabled entity
// slot in order with a done/timeout handshake, then runs one collision phase.
module frame_update_sequencer #(
   parameter int NUM_SLOTS = 3,
   parameter int INPUT_W   = 10,
   parameter int TIMEOUT   = 15,
   parameter int FRAME_DIV = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_start,
   input  logic [INPUT_W-1:0]   input_data,
   input  logic [NUM_SLOTS-1:0] slot_enable,
   input  logic [NUM_SLOTS-1:0] slot_done,
   input  logic                 collision_done,
   output logic [NUM_SLOTS-1:0] slot_trigger,
   output logic [INPUT_W-1:0]   latched_input,
   output logic                 collision_start,
   output logic                 frame_done,
   output logic                 busy,
   output logic                 frame_overrun,
   output logic [NUM_SLOTS:0]   timeout_flags
);

   localparam int SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int TIMER_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int FCNT_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [NUM_SLOTS-1:0] SLOT_ONE = NUM_SLOTS'(1);

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      TRIG,
      WAIT,
      COLLIDE,
      DONE
   } state_t;

   state_t                 state_q;
   logic [SLOT_W-1:0]      slot_idx_q;
   logic [TIMER_W-1:0]     timer_q;
   logic [FCNT_W-1:0]      frame_cnt_q;
   logic [NUM_SLOTS-1:0]   slot_trigger_q;
   logic [INPUT_W-1:0]     latched_input_q;
   logic                   collision_start_q;
   logic                   frame_done_q;
   logic                   busy_q;
   logic                   frame_overrun_q;
   logic [NUM_SLOTS:0]     timeout_flags_q;

   logic slot_en_cur;
   logic slot_done_cur;
   logic timer_expired;
   logic last_slot;
   logic wait_sampling;
   logic advance;

   // The trigger cycle itself is not a sampling cycle, so a stale done level is ignored.
   always_comb begin
      slot_en_cur   = slot_enable[slot_idx_q];
      slot_done_cur = slot_done[slot_idx_q];
      timer_expired = (timer_q == TIMER_W'(TIMEOUT));
      last_slot     = (slot_idx_q == SLOT_W'(NUM_SLOTS - 1));
      wait_sampling = (state_q == WAIT) && (slot_trigger_q == '0);
      advance       = ((state_q == TRIG) && !slot_en_cur) ||
                      (wait_sampling && (slot_done_cur || timer_expired));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q           <= IDLE;
         slot_idx_q        <= '0;
         timer_q           <= '0;
         frame_cnt_q       <= '0;
         slot_trigger_q    <= '0;
         latched_input_q   <= '0;
         collision_start_q <= 1'b0;
         frame_done_q      <= 1'b0;
         busy_q            <= 1'b0;
         frame_overrun_q   <= 1'b0;
         timeout_flags_q   <= '0;
      end else begin
         slot_trigger_q    <= '0;
         collision_start_q <= 1'b0;
         frame_done_q      <= 1'b0;

         if (frame_start && (state_q != IDLE)) begin
            frame_overrun_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (frame_start) begin
                  if (frame_cnt_q == FCNT_W'(FRAME_DIV - 1)) begin
                     frame_cnt_q <= '0;
                     busy_q      <= 1'b1;
                     state_q     <= LATCH;
                  end else begin
                     frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                  end
               end
            end
            LATCH: begin
               latched_input_q <= input_data;
               slot_idx_q      <= '0;
               state_q         <= TRIG;
            end
            TRIG: begin
               if (slot_en_cur) begin
                  slot_trigger_q <= SLOT_ONE << slot_idx_q;
                  timer_q        <= '0;
                  state_q        <= WAIT;
               end
            end
            WAIT: begin
               if (wait_sampling && !slot_done_cur) begin
                  if (timer_expired) begin
                     timeout_flags_q[slot_idx_q] <= 1'b1;
                  end else begin
                     timer_q <= timer_q + TIMER_W'(1);
                  end
               end
            end
            COLLIDE: begin
               // The collision_start cycle is skipped for the same reason as the trigger cycle.
               if (!collision_start_q) begin
                  if (collision_done) begin
                     frame_done_q <= 1'b1;
                     state_q      <= DONE;
                  end else if (timer_expired) begin
                     timeout_flags_q[NUM_SLOTS] <= 1'b1;
                     frame_done_q               <= 1'b1;
                     state_q                    <= DONE;
                  end else begin
                     timer_q <= timer_q + TIMER_W'(1);
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase

         if (advance) begin
            if (last_slot) begin
               collision_start_q <= 1'b1;
               timer_q           <= '0;
               state_q           <= COLLIDE;
            end else begin
               slot_idx_q <= slot_idx_q + SLOT_W'(1);
               state_q    <= TRIG;
            end
         end
      end
   end

   assign slot_trigger    = slot_trigger_q;
   assign latched_input   = latched_input_q;
   assign collision_start = collision_start_q;
   assign frame_done      = frame_done_q;
   assign busy            = busy_q;
   assign frame_overrun   = frame_overrun_q;
   assign timeout_flags   = timeout_flags_q;

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Scoreboard bench for frame_update_sequencer: directed passes push expected
// trigger/collision/done events; a negedge monitor pops and compares them.
module tb_frame_update_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       frame_start;
   logic [9:0] input_data;
   logic [2:0] slot_enable;
   logic [2:0] slot_done;
   logic       collision_done;
   logic [2:0] slot_trigger;
   logic [9:0] latched_input;
   logic       collision_start;
   logic       frame_done;
   logic       busy;
   logic       frame_overrun;
   logic [3:0] timeout_flags;

   logic       frame_start3;
   logic [9:0] input_data3;
   logic [2:0] slot_enable3;
   logic [2:0] slot_done3;
   logic       collision_done3;
   logic [2:0] slot_trigger3;
   logic [9:0] latched_input3;
   logic       collision_start3;
   logic       frame_done3;
   logic       busy3;
   logic       frame_overrun3;
   logic [3:0] timeout_flags3;

   frame_update_sequencer #(.NUM_SLOTS(3), .INPUT_W(10), .TIMEOUT(15), .FRAME_DIV(1)) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .input_data(input_data),
      .slot_enable(slot_enable), .slot_done(slot_done), .collision_done(collision_done),
      .slot_trigger(slot_trigger), .latched_input(latched_input),
      .collision_start(collision_start), .frame_done(frame_done), .busy(busy),
      .frame_overrun(frame_overrun), .timeout_flags(timeout_flags)
   );

   frame_update_sequencer #(.NUM_SLOTS(3), .INPUT_W(10), .TIMEOUT(15), .FRAME_DIV(3)) dut3 (
      .clk(clk), .reset(reset), .frame_start(frame_start3), .input_data(input_data3),
      .slot_enable(slot_enable3), .slot_done(slot_done3), .collision_done(collision_done3),
      .slot_trigger(slot_trigger3), .latched_input(latched_input3),
      .collision_start(collision_start3), .frame_done(frame_done3), .busy(busy3),
      .frame_overrun(frame_overrun3), .timeout_flags(timeout_flags3)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int fd_count = 0;
   int fd3_count = 0;
   int trig_cyc[3];
   int sdelay[3];
   int scnt[3];
   int cdelay = 0;
   int ccnt = 0;
   logic [15:0] sb[$];

   function automatic logic [15:0] ev(input logic [1:0] kind, input logic [13:0] payload);
      return {kind, payload};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end else begin
         $display("ok   %s: %0h", name, got);
      end
   endtask

   task automatic mon_check(input string name, input logic [15:0] got);
      logic [15:0] exp;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s: unexpected event %0h with empty scoreboard", name, got);
      end else begin
         exp = sb.pop_front();
         if (got !== exp) begin
            bad++;
            $display("FAIL %s: got event %0h required %0h", name, got, exp);
         end else begin
            $display("ok   %s: event %0h at cycle %0d", name, got, cyc);
         end
      end
   endtask

   // Monitor: every visible output event is compared against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (slot_trigger != 3'b000) begin
            for (int i = 0; i < 3; i++) if (slot_trigger[i]) trig_cyc[i] = cyc;
            mon_check("slot_trigger", ev(2'd0, {11'd0, slot_trigger}));
         end
         if (collision_start) mon_check("collision_start", ev(2'd1, 14'd0));
         if (frame_done) begin
            fd_count++;
            mon_check("frame_done", ev(2'd2, {timeout_flags, latched_input}));
         end
         if (frame_done3) fd3_count++;
      end
   end

   // Entity/collision responder: done pulses a programmed number of cycles after each trigger.
   initial begin
      slot_done = 3'b000;
      collision_done = 1'b0;
      for (int i = 0; i < 3; i++) scnt[i] = 0;
      forever begin
         @(negedge clk);
         slot_done = 3'b000;
         collision_done = 1'b0;
         if (!reset) begin
            for (int i = 0; i < 3; i++) scnt[i] = 0;
            ccnt = 0;
         end else begin
            for (int i = 0; i < 3; i++) begin
               if (scnt[i] > 0) begin
                  scnt[i]--;
                  if (scnt[i] == 0) slot_done[i] = 1'b1;
               end
               if (slot_trigger[i] && sdelay[i] > 0) scnt[i] = sdelay[i];
            end
            if (ccnt > 0) begin
               ccnt--;
               if (ccnt == 0) collision_done = 1'b1;
            end
            if (collision_start && cdelay > 0) ccnt = cdelay;
         end
      end
   end

   task automatic start_pass(input logic [9:0] data, input logic [2:0] en,
                             input int d0, input int d1, input int d2, input int cd);
      input_data = data;
      slot_enable = en;
      sdelay[0] = d0;
      sdelay[1] = d1;
      sdelay[2] = d2;
      cdelay = cd;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("pass ends (busy low)", {31'd0, busy}, 32'd0);
      check("scoreboard drained", sb.size(), 32'd0);
   endtask

   task automatic wait_trigger(input logic [2:0] t);
      int n = 0;
      while (slot_trigger != t && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reach trigger", {29'd0, slot_trigger}, {29'd0, t});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fd_snap;
      reset = 1'b0;
      frame_start = 1'b0;
      input_data = 10'h000;
      slot_enable = 3'b000;
      frame_start3 = 1'b0;
      input_data3 = 10'h123;
      slot_enable3 = 3'b000;
      slot_done3 = 3'b000;
      collision_done3 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sdelay[i] = 0;
         trig_cyc[i] = 0;
      end
      repeat (3) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset slot_trigger", {29'd0, slot_trigger}, 32'd0);
      check("reset latched_input", {22'd0, latched_input}, 32'd0);
      check("reset timeout_flags", {28'd0, timeout_flags}, 32'd0);
      check("reset frame_overrun", {31'd0, frame_overrun}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Nominal pass with latency checks.
      sb.push_back(ev(2'd0, 14'h001));
      sb.push_back(ev(2'd0, 14'h002));
      sb.push_back(ev(2'd0, 14'h004));
      sb.push_back(ev(2'd1, 14'h000));
      sb.push_back(ev(2'd2, {4'b0000, 10'h201}));
      start_pass(10'h201, 3'b111, 2, 2, 2, 1);
      check("busy after E0", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      check("latched_input after E1", {22'd0, latched_input}, 32'h201);
      @(posedge clk); #1;
      check("slot_trigger after E2", {29'd0, slot_trigger}, 32'd1);
      @(negedge clk);
      wait_idle();
      check("gap trig0->trig1", trig_cyc[1] - trig_cyc[0], 32'd4);
      check("gap trig1->trig2", trig_cyc[2] - trig_cyc[1], 32'd4);

      // Slot 1 disabled: one extra skip cycle.
      sb.push_back(ev(2'd0, 14'h001));
      sb.push_back(ev(2'd0, 14'h004));
      sb.push_back(ev(2'd1, 14'h000));
      sb.push_back(ev(2'd2, {4'b0000, 10'h155}));
      start_pass(10'h155, 3'b101, 2, 2, 2, 1);
      wait_idle();
      check("skip gap trig0->trig2", trig_cyc[2] - trig_cyc[0], 32'd5);

      // Slot 1 never finishes.
      sb.push_back(ev(2'd0, 14'h001));
      sb.push_back(ev(2'd0, 14'h002));
      sb.push_back(ev(2'd0, 14'h004));
      sb.push_back(ev(2'd1, 14'h000));
      sb.push_back(ev(2'd2, {4'b0010, 10'h3FF}));
      start_pass(10'h3FF, 3'b111, 2, 0, 2, 1);
      wait_idle();
      check("timeout_flags slot1", {28'd0, timeout_flags}, 32'b0010);

      // Overrun during WAIT; pass unaffected, sticky afterwards.
      check("overrun before", {31'd0, frame_overrun}, 32'd0);
      sb.push_back(ev(2'd0, 14'h001));
      sb.push_back(ev(2'd0, 14'h002));
      sb.push_back(ev(2'd0, 14'h004));
      sb.push_back(ev(2'd1, 14'h000));
      sb.push_back(ev(2'd2, {4'b0010, 10'h0AA}));
      start_pass(10'h0AA, 3'b111, 2, 2, 2, 1);
      wait_trigger(3'b010);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("overrun set", {31'd0, frame_overrun}, 32'd1);
      wait_idle();
      sb.push_back(ev(2'd0, 14'h001));
      sb.push_back(ev(2'd0, 14'h002));
      sb.push_back(ev(2'd0, 14'h004));
      sb.push_back(ev(2'd1, 14'h000));
      sb.push_back(ev(2'd2, {4'b0010, 10'h111}));
      start_pass(10'h111, 3'b111, 2, 2, 2, 1);
      check("new pass after overrun", {31'd0, busy}, 32'd1);
      wait_idle();
      check("overrun sticky", {31'd0, frame_overrun}, 32'd1);

      // All slots disabled, collision checker silent.
      sb.push_back(ev(2'd1, 14'h000));
      sb.push_back(ev(2'd2, {4'b1010, 10'h0F0}));
      start_pass(10'h0F0, 3'b000, 0, 0, 0, 0);
      wait_idle();
      check("collision timeout flag", {28'd0, timeout_flags}, 32'b1010);

      // Reset held 3 cycles mid-WAIT.
      sb.push_back(ev(2'd0, 14'h001));
      sb.push_back(ev(2'd0, 14'h002));
      start_pass(10'h2AB, 3'b111, 2, 0, 2, 1);
      wait_trigger(3'b010);
      repeat (3) @(negedge clk);
      fd_snap = fd_count;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("midreset busy", {31'd0, busy}, 32'd0);
      check("midreset slot_trigger", {29'd0, slot_trigger}, 32'd0);
      check("midreset latched_input", {22'd0, latched_input}, 32'd0);
      check("midreset timeout_flags", {28'd0, timeout_flags}, 32'd0);
      check("midreset frame_overrun", {31'd0, frame_overrun}, 32'd0);
      check("midreset collision_start", {31'd0, collision_start}, 32'd0);
      reset = 1'b1;
      repeat (30) @(negedge clk);
      check("no frame_done after reset", fd_count - fd_snap, 32'd0);
      check("midreset scoreboard drained", sb.size(), 32'd0);
      check("stays idle after reset", {31'd0, busy}, 32'd0);

      // Divide-by-3 instance: passes start on pulses 3 and 6.
      for (int k = 1; k <= 6; k++) begin
         frame_start3 = 1'b1;
         @(negedge clk);
         frame_start3 = 1'b0;
         check($sformatf("div3 pulse %0d busy", k), {31'd0, busy3}, (k % 3 == 0) ? 32'd1 : 32'd0);
         repeat (40) @(negedge clk);
      end
      check("div3 frame_done count", fd3_count, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
